// File: rtl/mem_burst_reader_if.sv
// Bundle of the burst reader's command, memory-port and output-stream signals.
//   master : the burst reader itself (takes commands, drives the memory address,
//            produces the output stream)
//   slave  : the surrounding environment (command source, memory, consumer)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command handshake
//   mem_addr/mem_data                    : one read port of the memory
//   out_valid/out_ready/out_data/out_last: output word stream
//   busy                                 : burst in progress
interface mem_burst_reader_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 14
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_data, out_ready,
    output cmd_ready, mem_addr, out_valid, out_data, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_data, out_ready,
    input  cmd_ready, mem_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/mem_burst_reader.sv
// Read-side burst front end for a memory port with one cycle of registered-address
// read latency. Accepts (addr, len) commands, walks the addresses with wrap-around,
// and delivers the returned words as a valid/ready stream with a last marker.
// Ports:
//   clk : clock, shared with the memory port
//   rst : synchronous active-high reset
//   bus : mem_burst_reader_if.master (command, memory port, output stream, busy)
module mem_burst_reader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 14,
  parameter int unsigned DEPTH  = 4
) (
  input logic                clk,
  input logic                rst,
  mem_burst_reader_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0]     DepthLim = (CntW + 1)'(DEPTH);
  localparam logic [PtrW-1:0]   PtrLast  = PtrW'(DEPTH - 1);
  localparam logic [ADDR_W:0]   RemOne   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              cmd_ready_q;
  logic              busy_q;

  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DEPTH-1:0]  fifo_last_q;
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [CntW-1:0]   count_q;

  logic [CntW:0]     credit_used;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;
  logic              head_last;

  // A read already in flight still needs a FIFO slot, so it counts against the credit.
  always_comb begin
    credit_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    issue       = (state_q == StIssue) && (credit_used < DepthLim);
    last_issue  = issue && (remaining_q == RemOne);
    push        = inflight_q;
    pop         = (count_q != '0) && bus.out_ready;
    head_last   = fifo_last_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            addr_q      <= bus.cmd_addr;
            // A zero length means the whole address space.
            remaining_q <= (bus.cmd_len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                               : {1'b0, bus.cmd_len};
            state_q     <= StIssue;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StIssue: begin
          if (issue) begin
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == RemOne) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && head_last) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_data_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wptr_q] <= bus.mem_data;
        fifo_last_q[wptr_q] <= inflight_last_q;
        wptr_q              <= (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = fifo_data_q[rptr_q];
  assign bus.out_last  = head_last;

endmodule

// File: tb/tb_mem_burst_reader.sv
module tb_mem_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_reader_if #(.ADDR_W(6), .DATA_W(14)) bus ();

  mem_burst_reader #(.ADDR_W(6), .DATA_W(14), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc          = 0;
  int max_occ      = 0;

  logic [13:0] mem [64];
  logic [13:0] got_data [$];
  logic        got_last [$];
  int          got_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory port with registered address: data for the address seen at an edge
  // appears in the following cycle.
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_last.push_back(bus.out_last);
      got_cyc.push_back(cyc);
    end
    if (int'(dut.count_q) > max_occ) max_occ = int'(dut.count_q);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic send_cmd(input logic [5:0] a, input logic [5:0] l);
    bit ok = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    acc = cyc;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 100 cycles");
    end
  endtask

  // Returns the cyc stamp of the first negedge where cmd_ready is seen high.
  task automatic wait_idle(input int budget, output int when);
    bit ok = 0;
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; when = cyc; break; end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL idle_timeout: got busy expected idle within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    do_reset();
    @(negedge clk);
    obs = {bus.cmd_ready, bus.busy, bus.out_valid, bus.out_last, bus.mem_addr, bus.out_data[9:0]};
    tests_run++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0} || bus.out_data !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy/busy/vld/last/addr=%b%b%b%b/%0d data=%h expected 1000/0 data=0",
               bus.cmd_ready, bus.busy, bus.out_valid, bus.out_last, bus.mem_addr, bus.out_data);
    end
  endtask

  task automatic test_basic();
    int when;
    clear_got();
    bus.out_ready = 1'b1;
    send_cmd(6'd5, 6'd4);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy: got busy=%b cmd_ready=%b expected busy=1 cmd_ready=0",
               bus.busy, bus.cmd_ready);
    end
    wait_idle(50, when);
    tests_run++;
    if (got_data.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d words expected 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_data[i] !== 14'h105 + 14'(i) || got_last[i] !== (i == 3) ||
            got_cyc[i] != acc + 2 + i) begin
          tests_failed++;
          $display("FAIL basic_word%0d: got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                   i, got_data[i], got_last[i], got_cyc[i], 14'h105 + 14'(i), (i == 3), acc + 2 + i);
        end
      end
    end
    tests_run++;
    if (when != acc + 6) begin
      tests_failed++;
      $display("FAIL basic_cmd_ready_timing: got cyc=%0d expected cyc=%0d", when, acc + 6);
    end
  endtask

  task automatic test_wrap();
    int when;
    logic [5:0] addrs [4];
    logic [5:0] exp_a [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
    logic [13:0] exp_d [4] = '{14'h13E, 14'h13F, 14'h100, 14'h101};
    clear_got();
    bus.out_ready = 1'b1;
    send_cmd(6'd62, 6'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addrs[i] = bus.mem_addr;
    end
    wait_idle(50, when);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (addrs[i] !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addrs[i], exp_a[i]);
      end
    end
    tests_run++;
    if (got_data.size() != 4) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d words expected 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
          tests_failed++;
          $display("FAIL wrap_word%0d: got %h/%b expected %h/%b",
                   i, got_data[i], got_last[i], exp_d[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_len0();
    int when;
    int nlast = 0;
    int bad = 0;
    clear_got();
    bus.out_ready = 1'b1;
    send_cmd(6'd0, 6'd0);
    wait_idle(200, when);
    repeat (5) @(negedge clk);
    tests_run++;
    if (got_data.size() != 64) begin
      tests_failed++;
      $display("FAIL len0_count: got %0d words expected 64", got_data.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (got_data[i] !== 14'h100 + 14'(i)) bad++;
        if (got_last[i]) nlast++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL len0_data: got %0d wrong words expected 0", bad);
      end
      tests_run++;
      if (nlast != 1 || got_last[63] !== 1'b1) begin
        tests_failed++;
        $display("FAIL len0_last: got %0d last flags (last[63]=%b) expected 1 on word 63",
                 nlast, got_last[63]);
      end
    end
  endtask

  task automatic test_backpressure();
    int when;
    bit stable = 1;
    clear_got();
    bus.out_ready = 1'b0;
    send_cmd(6'd5, 6'd8);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 3 && (bus.out_valid !== 1'b1 || bus.out_data !== 14'h105)) stable = 0;
    end
    tests_run++;
    if (bus.mem_addr !== 6'd9) begin
      tests_failed++;
      $display("FAIL bp_issue_count: got mem_addr=%0d expected 9 (4 issues)", bus.mem_addr);
    end
    tests_run++;
    if (!stable || got_data.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: got valid=%b data=%h popped=%0d expected valid=1 data=105 popped=0",
               bus.out_valid, bus.out_data, got_data.size());
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle(50, when);
    tests_run++;
    if (got_data.size() != 8) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d words expected 8", got_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_data[i] !== 14'h105 + 14'(i) || got_last[i] !== (i == 7)) begin
          tests_failed++;
          $display("FAIL bp_word%0d: got %h/%b expected %h/%b",
                   i, got_data[i], got_last[i], 14'h105 + 14'(i), (i == 7));
        end
      end
    end
  endtask

  task automatic test_random_ready();
    bit done = 0;
    int bad = 0;
    int nlast = 0;
    clear_got();
    max_occ = 0;
    bus.out_ready = 1'b0;
    send_cmd(6'd20, 6'd16);
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.cmd_ready) done = 1;
    end
    bus.out_ready = 1'b1;
    tests_run++;
    if (!done || got_data.size() != 16) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d words (done=%b) expected 16", got_data.size(), done);
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (got_data[i] !== 14'h114 + 14'(i)) bad++;
        if (got_last[i]) nlast++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL rand_order: got %0d wrong words expected 0", bad);
      end
      tests_run++;
      if (nlast != 1 || got_last[15] !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_last: got %0d last flags expected 1 on word 15", nlast);
      end
    end
    tests_run++;
    if (max_occ > 4) begin
      tests_failed++;
      $display("FAIL rand_occupancy: got max %0d expected <= 4", max_occ);
    end
  endtask

  task automatic test_reset_mid();
    int when;
    bit ok = 0;
    clear_got();
    bus.out_ready = 1'b1;
    send_cmd(6'd0, 6'd10);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (got_data.size() >= 3) begin ok = 1; break; end
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (!ok || bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_state: got valid=%b cmd_ready=%b busy=%b expected 0/1/0",
               bus.out_valid, bus.cmd_ready, bus.busy);
    end
    tests_run++;
    if (got_data.size() != 3 || got_data[0] !== 14'h100 || got_data[2] !== 14'h102) begin
      tests_failed++;
      $display("FAIL rstmid_words: got %0d words expected 3 (100..102)", got_data.size());
    end
    clear_got();
    send_cmd(6'd0, 6'd1);
    wait_idle(50, when);
    repeat (4) @(negedge clk);
    tests_run++;
    if (got_data.size() != 1 || got_data[0] !== 14'h100 || got_last[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_new_cmd: got %0d words first=%h expected 1 word 100 last=1",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 14'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 14'h100 + 14'(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_backpressure();
    test_random_ready();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
Read-side front end for the dual-port 64x14 Memory block. It accepts a burst command (start address, length), drives one memory read port's address, absorbs that port's one-cycle registered-address read latency, and delivers the words as a valid/ready stream with a last marker. It sits directly between a memory read port (write_en tied 0) and a downstream stream consumer that may apply backpressure.

Parameters:
ADDR_W, 6, memory address width; address space is 2**ADDR_W words.
DATA_W, 14, memory word width.
DEPTH, 4, output FIFO entries; legal minimum is 3, which is required for 1 word/cycle throughput.

Ports:
clk  input  1  clock; the memory port clock is the same clk.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  burst command present.
cmd_ready  output  1  block idle, can accept a command.
cmd_addr  input  ADDR_W  first word address.
cmd_len  input  ADDR_W  word count; 0 encodes 2**ADDR_W (64).
mem_addr  output  ADDR_W  to memory portN_addr.
mem_data  input  DATA_W  from memory portN_data_out.
out_valid  output  1  stream word valid.
out_ready  input  1  consumer accepts the word.
out_data  output  DATA_W  stream word.
out_last  output  1  marks the final word of the burst.
busy  output  1  burst in progress: issuing, in flight, or FIFO non-empty.

Behaviour:
- Reset (rst=1 sampled at posedge): cmd_ready=1, busy=0, out_valid=0, out_data=0, out_last=0, mem_addr=0. FIFO is emptied, the in-flight flag is cleared, and the remaining count is 0. Reset mid-burst abandons the burst and delivers no further words.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: cmd_ready=1. A command is accepted on a cycle with cmd_valid && cmd_ready. On that edge the block loads addr=cmd_addr and remaining=cmd_len (0 -> 64), then goes to ISSUE.
- ISSUE: mem_addr is a register. An issue happens in cycle k when occ + inflight < DEPTH, where occ is the FIFO occupancy and inflight is the 1-bit flag "issued last cycle".
  - On an issue, mem_addr presents A in cycle k. mem_data is valid in cycle k+1 and is pushed to the FIFO at the end of k+1, tagged last if it was the final issue.
  - After each issue, addr increments modulo 2**ADDR_W (63 wraps to 0) and remaining decrements.
  - When remaining reaches 0, go to DRAIN.
  - mem_addr holds its value when no issue occurs.
- DRAIN: no issues. Return to IDLE on the edge where the last-tagged word is popped. cmd_ready rises the cycle after that pop; commands are never overlapped.
- Output side:
  - out_valid = FIFO non-empty; out_data and out_last show the FIFO head.
  - Pop on out_valid && out_ready.
  - A push and a pop in the same cycle leave occ unchanged.
  - out_data and out_last hold their values while out_valid=0 && out_ready=0.
- Latency: command accepted at the end of cycle c; first issue in c+1; first out_valid in c+3. With out_ready held at 1, one word per cycle follows; a len-L burst's last word appears in c+L+2.
- Backpressure: the credit rule guarantees the FIFO never overflows, so a FIFO push with occ==DEPTH is a bench assertion failure. With out_ready=0 the block issues exactly DEPTH reads, then stalls.
- busy = (state != IDLE).

Test Plan:
- Memory preloaded with mem[i]=0x100+i; cmd addr=5, len=4, out_ready=1 -> out_data 0x105, 0x106, 0x107, 0x108 on consecutive cycles c+3..c+6, out_last only on 0x108, cmd_ready back to 1 at c+7.
- Wrap: addr=62, len=4 -> 0x13E, 0x13F, 0x100, 0x101; mem_addr sequence 62, 63, 0, 1.
- len=0 from addr=0 -> exactly 64 words 0x100..0x13F; last on 0x13F; no 65th word.
- Backpressure: len=8, out_ready=0 for 10 cycles -> exactly 4 issues, then out_valid held with data 0x105 stable; release out_ready -> all 8 words delivered in order with no loss or duplication.
- Random out_ready (50%), len=16 -> in-order data, a single out_last, FIFO occupancy never above DEPTH.
- rst asserted after 3 words of a len=10 burst -> next cycle out_valid=0, cmd_ready=1, busy=0; a new cmd addr=0, len=1 then returns only 0x100 with last=1.
